// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state enum and its width.
// RST_SEQ_REVERSE_ASSERT_EN adds the SW_ASSERT state and widens state to 3 bits.
package rst_seq_pkg;

`ifdef RST_SEQ_REVERSE_ASSERT_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT  = STATE_W'(0),
    ST_RELEASE = STATE_W'(1),
    ST_DONE    = STATE_W'(2),
    ST_SW_HOLD = STATE_W'(3)
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    , ST_SW_ASSERT = STATE_W'(4)
`endif
  } rst_seq_state_e;

  function automatic int cnt_width(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-release reset synchronizer, SYNC_STAGES flops deep.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_ni,
  output logic rst_sync_no
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered domain-reset sequencer with four-phase software reset handshake.
// Build option: RST_SEQ_REVERSE_ASSERT_EN asserts outputs in reverse order on a software reset.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STEP_DLY    = 16,
  parameter int HOLD_CYC    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               seq_done,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX = (STEP_DLY > HOLD_CYC) ? STEP_DLY : HOLD_CYC;
  localparam int CNT_W   = cnt_width(STEP_DLY, HOLD_CYC);
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] STEP_TC   = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

  rst_seq_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               ack_q, ack_d;
  logic               rst_sync_n;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk),
    .arst_ni     (reset_n),
    .rst_sync_no (rst_sync_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ack_d   = ack_q;
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      // The ASSERT exit edge counts as the first step cycle, so output i
      // lands at SYNC_STAGES + (i+1)*STEP_DLY edges after reset release.
      ST_ASSERT, ST_RELEASE: begin
        if (state_q == ST_RELEASE || rst_sync_n) begin
          state_d = ST_RELEASE;
          if (cnt_q == STEP_TC) begin
            rst_d[idx_q] = 1'b1;
            cnt_d        = '0;
            if (idx_q == LAST_IDX) state_d = ST_DONE;
            else                   idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          cnt_d = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          rst_d[NUM_OUT-1] = 1'b0;
          idx_d            = LAST_IDX;
          state_d          = (NUM_OUT == 1) ? ST_SW_HOLD : ST_SW_ASSERT;
`else
          rst_d   = '0;
          state_d = ST_SW_HOLD;
`endif
        end
      end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
      ST_SW_ASSERT: begin
        if (cnt_q == STEP_TC) begin
          rst_d[idx_q - IDX_W'(1)] = 1'b0;
          idx_d = idx_q - IDX_W'(1);
          cnt_d = '0;
          if (idx_q == IDX_W'(1)) state_d = ST_SW_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      ST_SW_HOLD: begin
        // Hold always runs to completion; ack only if the request survives it.
        if (cnt_q != HOLD_FULL) begin
          cnt_d = cnt_inc;
          if (cnt_q == HOLD_TC) begin
            if (sw_rst_req) begin
              ack_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end
        end else if (!sw_rst_req) begin
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

  always_comb begin
    rst_n_out  = rst_q;
    sw_rst_ack = ack_q;
    seq_done   = (state_q == ST_DONE);
    state      = state_q;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl against an edge-count reference model.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int N = 4, SYNC = 2, STEP = 16, HOLD = 8;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  localparam int ZOFF = REV ? (N - 1) * STEP : 0;
  localparam int HONOR_ST = REV ? 4 : 3;

  logic clk = 1'b0, reset_n = 1'b1, sw_rst_req = 1'b0;
  logic sw_rst_ack, seq_done;
  logic [N-1:0] rst_n_out;
  logic [STATE_W-1:0] state;
  int tests = 0, fails = 0;

  rst_seq_ctrl #(.NUM_OUT(N), .SYNC_STAGES(SYNC), .STEP_DLY(STEP), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .state(state));

  always #5 clk = ~clk;

  // Model: t = edges since the phase anchor; released count = (t-off)/STEP.
  typedef enum int {M_REL, M_HOLD, M_REV} mph_e;
  mph_e ph;
  int t, off, k, n, exp_st;
  logic m_ack, exp_done;
  logic [N-1:0] exp_rst;
  logic [N+STATE_W+1:0] obs, expv;

  always_comb begin
    k = t - off; n = 0; exp_st = 0; exp_done = 1'b0;
    case (ph)
      M_REL: begin
        n = (k <= 0) ? 0 : k / STEP;
        if (n > N) n = N;
        exp_done = (n == N);
        exp_st = exp_done ? 2 : ((off > 0 && t <= off) ? 0 : 1);
      end
      M_HOLD: exp_st = 3;
      default: begin n = N - 1 - t / STEP; exp_st = 4; end
    endcase
    exp_rst = N'((1 << n) - 1);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= M_REL; t <= 0; off <= SYNC; m_ack <= 1'b0;
    end else begin
      case (ph)
        M_REL:
          if (exp_done && sw_rst_req) begin
            t <= 0;
            ph <= (REV && N > 1) ? M_REV : M_HOLD;
          end else if (!exp_done) t <= t + 1;
        M_REV:
          if (t + 1 == (N - 1) * STEP) begin ph <= M_HOLD; t <= 0; end
          else t <= t + 1;
        default:
          if (t + 1 < HOLD) t <= t + 1;
          else if (t + 1 == HOLD) begin
            if (sw_rst_req) begin m_ack <= 1'b1; t <= t + 1; end
            else begin ph <= M_REL; off <= 0; t <= 0; end
          end else if (!sw_rst_req) begin
            m_ack <= 1'b0; ph <= M_REL; off <= 0; t <= 0;
          end
      endcase
    end
  end

  assign obs  = {rst_n_out, seq_done, sw_rst_ack, state};
  assign expv = {exp_rst, exp_done, m_ack, STATE_W'(exp_st)};

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset_async got=%h want=0", obs); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== '0 || obs !== expv) begin
        fails++; $display("FAIL reset_hold got=%h want=0 model=%h", obs, expv);
      end
    end
  endtask

  task automatic test_power_on();
    logic [N-1:0] pat [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    reset_n = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL power_on_model e=%0d got=%h want=%h", e, obs, expv); end
      if (e == 17) begin
        tests++;
        if (rst_n_out !== 4'b0000) begin fails++; $display("FAIL power_on_e17 got=%b want=0000", rst_n_out); end
      end
      if (e >= 18 && (e - 18) % 16 == 0 && e <= 66) begin
        tests++;
        if (rst_n_out !== pat[(e - 18) / 16]) begin
          fails++; $display("FAIL power_on_release e=%0d got=%b want=%b", e, rst_n_out, pat[(e - 18) / 16]);
        end
      end
      if (e == 65 || e == 66) begin
        tests++;
        if (seq_done !== (e == 66)) begin fails++; $display("FAIL power_on_done e=%0d got=%b want=%b", e, seq_done, e == 66); end
      end
    end
  endtask

  task automatic test_sw_reset();
    int z, ack_e, drop, af, rel0, dn;
    z = 1 + ZOFF; ack_e = z + HOLD; drop = ack_e + 3; af = drop + 1;
    rel0 = af + STEP; dn = af + N * STEP;
    sw_rst_req = 1'b1;
    for (int e = 1; e <= dn + 3; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL sw_reset_model e=%0d got=%h want=%h", e, obs, expv); end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
      if (e == 1 || e == 1 + STEP || e == 1 + 2 * STEP) begin
        tests++;
        if (rst_n_out !== N'((1 << (N - 1 - (e - 1) / STEP)) - 1)) begin
          fails++; $display("FAIL sw_reset_rev_order e=%0d got=%b", e, rst_n_out);
        end
      end
`endif
      if (e == z) begin
        tests++;
        if (rst_n_out !== '0) begin fails++; $display("FAIL sw_reset_assert got=%b want=0000", rst_n_out); end
      end
      if (e == ack_e - 1 || e == ack_e || e == af) begin
        tests++;
        if (sw_rst_ack !== (e == ack_e)) begin
          fails++; $display("FAIL sw_reset_ack e=%0d got=%b want=%b", e, sw_rst_ack, e == ack_e);
        end
      end
      if (e == rel0 - 1 || e == rel0) begin
        tests++;
        if (rst_n_out[0] !== (e == rel0)) begin
          fails++; $display("FAIL sw_reset_replay e=%0d got=%b want=%b", e, rst_n_out[0], e == rel0);
        end
      end
      if (e == dn - 1 || e == dn) begin
        tests++;
        if (seq_done !== (e == dn)) begin
          fails++; $display("FAIL sw_reset_done e=%0d got=%b want=%b", e, seq_done, e == dn);
        end
      end
      if (e == drop) sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int e = 1; e <= 40; e++) @(negedge clk);
    tests++;
    if (rst_n_out !== 4'b0011) begin fails++; $display("FAIL mid_reset_pre got=%b want=0011", rst_n_out); end
    reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL mid_reset_async got=%h want=0", obs); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL mid_reset_model e=%0d got=%h want=%h", e, obs, expv); end
      if (e == 17 || e == 18) begin
        tests++;
        if (rst_n_out[0] !== (e == 18)) begin
          fails++; $display("FAIL mid_reset_restart e=%0d got=%b want=%b", e, rst_n_out[0], e == 18);
        end
      end
    end
  endtask

  task automatic test_early_req();
    int z, ack_e;
    z = 67 + ZOFF; ack_e = z + HOLD;
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int e = 1; e <= ack_e + 4 + N * STEP; e++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL early_req_model e=%0d got=%h want=%h", e, obs, expv); end
      if (e == 40) begin
        tests++;
        if (state !== STATE_W'(1) || sw_rst_ack !== 1'b0) begin
          fails++; $display("FAIL early_req_ignored state=%0d ack=%b want state=1 ack=0", state, sw_rst_ack);
        end
      end
      if (e == 66 || e == 67) begin
        tests++;
        if (state !== STATE_W'(e == 66 ? 2 : HONOR_ST)) begin
          fails++; $display("FAIL early_req_honour e=%0d got=%0d want=%0d", e, state, e == 66 ? 2 : HONOR_ST);
        end
      end
      if (e == ack_e - 1 || e == ack_e) begin
        tests++;
        if (sw_rst_ack !== (e == ack_e)) begin
          fails++; $display("FAIL early_req_ack e=%0d got=%b want=%b", e, sw_rst_ack, e == ack_e);
        end
      end
      if (e == 20) sw_rst_req = 1'b1;
      if (e == ack_e + 2) sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_early_withdraw();
    int z, rel0, dn;
    logic ack_seen;
    z = 1 + ZOFF; rel0 = z + HOLD + STEP; dn = z + HOLD + N * STEP;
    ack_seen = 1'b0;
    sw_rst_req = 1'b1;
    for (int e = 1; e <= dn + 2; e++) begin
      @(negedge clk);
      ack_seen = ack_seen | sw_rst_ack;
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL withdraw_model e=%0d got=%h want=%h", e, obs, expv); end
      if (e == rel0 - 1 || e == rel0) begin
        tests++;
        if (rst_n_out[0] !== (e == rel0)) begin
          fails++; $display("FAIL withdraw_replay e=%0d got=%b want=%b", e, rst_n_out[0], e == rel0);
        end
      end
      if (e == dn) begin
        tests++;
        if (seq_done !== 1'b1) begin fails++; $display("FAIL withdraw_done got=%b want=1", seq_done); end
      end
      if (e == z + 3) sw_rst_req = 1'b0;
    end
    tests++;
    if (ack_seen !== 1'b0) begin fails++; $display("FAIL withdraw_no_ack got=%b want=0", ack_seen); end
  endtask

  task automatic test_random();
    int hold_cnt;
    hold_cnt = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL random_model c=%0d got=%h want=%h", c, obs, expv); end
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
      hold_cnt--;
      if (hold_cnt <= 0) begin
        sw_rst_req = ~sw_rst_req;
        hold_cnt = $urandom_range(1, 90);
      end
    end
    sw_rst_req = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_mid_reset();
    test_early_req();
    test_early_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

- Sits directly downstream of the bench clock/reset interface: consumes `clk` and the raw asynchronous `reset_n`, and produces `NUM_OUT` ordered, synchronously released domain resets.
- Releases the domain resets one at a time with a fixed cycle spacing, then raises `seq_done`.
- Supports a four-phase software reset request/acknowledge that re-asserts the domain resets and replays the release sequence.
- Used by DUT wrappers and as a synthesizable reference for reset-ordering checks.

## Interface
Parameters:
- `NUM_OUT`, default 4: number of domain reset outputs; range 1–16.
- `SYNC_STAGES`, default 2: synchronizer depth; minimum 2.
- `STEP_DLY`, default 16: cycles between successive releases; minimum 1.
- `HOLD_CYC`, default 8: cycles all outputs are held asserted on a software reset; minimum 1.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `sw_rst_req`, in, 1: software reset request, four-phase level.
- `sw_rst_ack`, out, 1: software reset acknowledge, four-phase level.
- `rst_n_out`, out, `NUM_OUT`: domain resets, active-low; bit 0 released first.
- `seq_done`, out, 1: high when all outputs are released.
- `state`, out, 2: current FSM state, for debug.

## Operation
- **Synchronizer:**
  - `reset_n` low clears the sync chain asynchronously.
  - `rst_sync_n` rises `SYNC_STAGES` rising edges after `reset_n` rises.
- **FSM states:** `ASSERT`=0, `RELEASE`=1, `DONE`=2, `SW_HOLD`=3.
- **`ASSERT`:** all outputs 0. When `rst_sync_n`=1: clear the counter and go to `RELEASE`.
- **`RELEASE`:**
  - Counter counts 1..`STEP_DLY`.
  - At terminal count, release the next output (index `idx`), set `idx`++ and clear the counter.
  - After output `NUM_OUT-1` is released, go to `DONE`.
- **`DONE`:** `seq_done`=1. If `sw_rst_req`=1: go to `SW_HOLD`, and all outputs go to 0 on that edge.
- **`SW_HOLD`:**
  - Counter counts to `HOLD_CYC`, then `sw_rst_ack`=1.
  - `sw_rst_ack` stays 1 while `sw_rst_req`=1.
  - When `sw_rst_req` falls: `sw_rst_ack`=0 on the next edge, clear `idx`, go to `RELEASE`.
- **Counter width:** `$clog2(max(STEP_DLY,HOLD_CYC)+1)`. The counter saturates and never wraps.
- **Request outside `DONE`:** `sw_rst_req` is ignored in `ASSERT` and `RELEASE`; `sw_rst_ack` stays 0. A request still high when `DONE` is reached is honoured on the next edge.
- **Request withdrawn early:** if `sw_rst_req` falls in `SW_HOLD` before the hold completes, the hold still completes, `sw_rst_ack` is never raised, then go to `RELEASE`.
- **Reset mid-operation:** `reset_n` low in any state immediately and asynchronously sets all outputs to 0, `sw_rst_ack`=0, `seq_done`=0 and `state`=`ASSERT`.

## Timing
- **Reset values:**
  - `rst_n_out`='0
  - `sw_rst_ack`=0
  - `seq_done`=0
  - `state`=`ASSERT`
  - counter=0
  - `idx`=0
- **Release timing after power-on:** edge 1 is the first rising edge after `reset_n` rises. Output `i` rises at edge `SYNC_STAGES + (i+1)*STEP_DLY`.
- **`seq_done`:** rises on the same edge as the last release.
- **Software reset assert:** outputs fall one edge after `sw_rst_req` is sampled high in `DONE`.
- **Software reset ack:** `sw_rst_ack` rises `HOLD_CYC` edges later.
- **Software replay timing:** output `i` rises `(i+1)*STEP_DLY` edges after the edge on which `sw_rst_ack` falls.
- **Registered outputs:** all outputs come from registers; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `RST_SEQ_REVERSE_ASSERT_EN`.
- **Defined:**
  - On `sw_rst_req`, outputs are asserted in reverse order (`NUM_OUT-1` first), one every `STEP_DLY` cycles.
  - `HOLD_CYC` counting starts after output 0 is asserted.
  - Adds the extra state `SW_ASSERT`=4, so `state` widens to 3 bits.
- **Undefined:** all outputs assert simultaneously, as described under Operation.
- **Either way:** power-on reset always asserts all outputs simultaneously.

## Structure
- **`rst_seq_pkg`:** holds the state enum `rst_seq_state_e` and the `state` width constant, which is conditional on the macro.
- **Sub-module `rst_sync`:** async-assert/sync-release synchronizer, parameterized by `SYNC_STAGES`. The top level instantiates it once.

## Test plan
All scenarios use the default parameters.
- **Power-on:** `reset_n` rises → `rst_n_out` goes 0001, 0011, 0111, 1111 at edges 18, 34, 50 and 66; `seq_done` rises at edge 66.
- **Software reset:** raise `sw_rst_req` in `DONE` → `rst_n_out`=0000 on the next edge; `sw_rst_ack`=1 8 edges later. Drop the request → ack falls; bit 0 released 16 edges after that, `seq_done` 64 edges after.
- **Reset mid-sequence:** pull `reset_n` low at edge 40 (value 0011) → outputs 0000 asynchronously, `state`=0. Release it → the full sequence restarts, first release at +18.
- **Early request:** `sw_rst_req` high at edge 20 → ignored until `DONE` at edge 66, then honoured; `sw_rst_ack` stays 0 until 8 edges into the hold.
- **Early withdrawal:** drop `sw_rst_req` after 3 hold cycles → `sw_rst_ack` never pulses; release sequence restarts after the 8-cycle hold.
- **Macro defined:** software reset → `rst_n_out` goes 0111, 0011, 0001, 0000 at 16-edge spacing; ack 8 edges after 0000.
